// File: rtl/dmem_port_arbiter.sv
// Two-requester (core / debug) arbiter for the single-port data memory with
// starvation guard, debug burst lock and in-order response routing.
// Optional grant/conflict statistics are compiled in with `define DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_wsel,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_wsel,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wsel,
  input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_core_grants,
  output logic [31:0]       stat_dbg_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_SAT   = 8'hFF;

  logic                    core_req_s;
  logic                    dbg_req_s;
  logic                    core_win_s;
  logic                    dbg_win_s;
  logic [7:0]              wait_d;
  logic [7:0]              wait_q;
  logic [READ_LATENCY-1:0] pv_d;
  logic [READ_LATENCY-1:0] pv_q;
  logic [READ_LATENCY-1:0] po_d;
  logic [READ_LATENCY-1:0] po_q;

  // Requests are masked while reset is held so grants and mem_en stay low.
  always_comb begin
    core_req_s = core_req & reset_n;
    dbg_req_s  = dbg_req & reset_n;
    core_win_s = 1'b0;
    dbg_win_s  = 1'b0;
    if (dbg_req_s && (dbg_lock || (wait_q >= MAX_WAIT_C))) begin
      dbg_win_s = 1'b1;
    end else if (core_req_s) begin
      core_win_s = 1'b1;
    end else if (dbg_req_s) begin
      dbg_win_s = 1'b1;
    end else begin
      core_win_s = 1'b0;
      dbg_win_s  = 1'b0;
    end
  end

  always_comb begin
    wait_d = 8'd0;
    if (dbg_req_s && !dbg_win_s) begin
      wait_d = (wait_q == WAIT_SAT) ? WAIT_SAT : (wait_q + 8'd1);
    end else begin
      wait_d = 8'd0;
    end
  end

  assign core_gnt = core_win_s;
  assign dbg_gnt  = dbg_win_s;

  always_comb begin
    mem_en    = core_win_s | dbg_win_s;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_wsel  = 4'h0;
    if (dbg_win_s) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wsel  = dbg_wsel;
    end else if (core_win_s) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_wsel  = core_wsel;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Response pipeline: valid/owner pairs (owner 1 = debug) track each issued access.
  always_comb begin
    pv_d    = '0;
    po_d    = '0;
    pv_d[0] = mem_en;
    po_d[0] = dbg_win_s;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q <= 8'd0;
      pv_q   <= '0;
      po_q   <= '0;
    end else begin
      wait_q <= wait_d;
      pv_q   <= pv_d;
      po_q   <= po_d;
    end
  end

  always_comb begin
    core_rvalid = pv_q[READ_LATENCY-1] & ~po_q[READ_LATENCY-1];
    dbg_rvalid  = pv_q[READ_LATENCY-1] & po_q[READ_LATENCY-1];
    core_rdata  = core_rvalid ? mem_rdata : 32'h0;
    dbg_rdata   = dbg_rvalid ? mem_rdata : 32'h0;
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] sc_d;
  logic [31:0] sc_q;
  logic [31:0] sd_d;
  logic [31:0] sd_q;
  logic [31:0] scf_d;
  logic [31:0] scf_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  always_comb begin
    sc_d  = sc_q;
    sd_d  = sd_q;
    scf_d = scf_q;
    if (stat_clr) begin
      sc_d  = 32'h0;
      sd_d  = 32'h0;
      scf_d = 32'h0;
    end else begin
      sc_d  = core_win_s ? sat_inc(sc_q) : sc_q;
      sd_d  = dbg_win_s ? sat_inc(sd_q) : sd_q;
      scf_d = (core_req_s && dbg_req_s) ? sat_inc(scf_q) : scf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_q  <= 32'h0;
      sd_q  <= 32'h0;
      scf_q <= 32'h0;
    end else begin
      sc_q  <= sc_d;
      sd_q  <= sd_d;
      scf_q <= scf_d;
    end
  end

  assign stat_core_grants = sc_q;
  assign stat_dbg_grants  = sd_q;
  assign stat_conflicts   = scf_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter (MAX_WAIT=4, READ_LATENCY=1)
// with a behavioural arbitration/memory model and directed boundary scenarios.
module tb_dmem_port_arbiter;
  localparam int AW = 16;
  localparam int RL = 1;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [31:0]   core_wdata = 32'h0;
  logic [3:0]    core_wsel = 4'h0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_wdata = 32'h0;
  logic [3:0]    dbg_wsel = 4'h0;
  logic          core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0]   core_rdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wsel;
  logic [31:0]   mem_rdata = 32'h0;
`ifdef DMEM_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_core_grants, stat_dbg_grants, stat_conflicts;
  int unsigned   ref_sc = 0, ref_sd = 0, ref_scf = 0;
`endif

  dmem_port_arbiter #(.ADDR_W(AW), .READ_LATENCY(RL), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wsel(core_wsel), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wsel(dbg_wsel), .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wsel(mem_wsel), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_clr(stat_clr), .stat_core_grants(stat_core_grants),
    .stat_dbg_grants(stat_dbg_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  typedef struct {
    bit          owner;
    bit          we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  bit   [31:0] tb_mem [0:65535];
  bit   [31:0] ref_mem [0:65535];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ref_wait = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Memory device: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= merge(tb_mem[mem_addr], mem_wdata, mem_wsel);
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  // Monitor: every response is matched in order against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (core_rvalid && dbg_rvalid) begin
      chk("both_rvalid", 32'(core_rvalid & dbg_rvalid), 32'h0);
    end else if (core_rvalid || dbg_rvalid) begin
      if (sb.size() == 0) begin
        chk("spurious_rvalid", 32'(core_rvalid | dbg_rvalid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", 32'(dbg_rvalid), 32'(e.owner));
        if (!e.we) chk("rsp_data", e.owner ? dbg_rdata : core_rdata, e.data);
        chk("rsp_other_rdata", e.owner ? core_rdata : dbg_rdata, 32'h0);
      end
    end else begin
      chk("idle_rdata", core_rdata | dbg_rdata, 32'h0);
    end
  end

  task automatic do_cycle(input bit creq, input bit cwe, input logic [15:0] caddr,
                          input logic [31:0] cwd, input logic [3:0] cws,
                          input bit dreq, input bit dwe, input logic [15:0] daddr,
                          input logic [31:0] dwd, input logic [3:0] dws, input bit lock,
                          output int ew, output int aw);
    exp_t e;
    @(negedge clk);
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd; core_wsel = cws;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd; dbg_wsel = dws;
    dbg_lock = lock;
    #1;
    if (dreq && (lock || ref_wait >= MW)) ew = 2;
    else if (creq)                        ew = 1;
    else if (dreq)                        ew = 2;
    else                                  ew = 0;
    aw = dbg_gnt ? 2 : (core_gnt ? 1 : 0);
    chk("core_gnt", 32'(core_gnt), 32'(ew == 1));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(ew == 2));
    chk("mem_en", 32'(mem_en), 32'(ew != 0));
    if (ew == 0) begin
      chk("mem_we_idle", 32'(mem_we), 32'h0);
    end else begin
      chk("mem_we", 32'(mem_we), 32'(ew == 2 ? dwe : cwe));
      chk("mem_addr", 32'(mem_addr), 32'(ew == 2 ? daddr : caddr));
      if (ew == 2 ? dwe : cwe) begin
        chk("mem_wdata", mem_wdata, ew == 2 ? dwd : cwd);
        chk("mem_wsel", 32'(mem_wsel), 32'(ew == 2 ? dws : cws));
      end
      e.owner = (ew == 2);
      e.we    = (ew == 2) ? dwe : cwe;
      if (ew == 2) begin
        e.data = ref_mem[daddr];
        if (dwe) ref_mem[daddr] = merge(ref_mem[daddr], dwd, dws);
      end else begin
        e.data = ref_mem[caddr];
        if (cwe) ref_mem[caddr] = merge(ref_mem[caddr], cwd, cws);
      end
      sb.push_back(e);
    end
    ref_wait = (dreq && ew != 2) ? ((ref_wait < 255) ? ref_wait + 1 : 255) : 0;
`ifdef DMEM_ARB_STATS_EN
    if (ew == 1) ref_sc++;
    if (ew == 2) ref_sd++;
    if (creq && dreq) ref_scf++;
`endif
  endtask

  task automatic idle_cycle();
    int ew, aw;
    do_cycle(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, ew, aw);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_core_gnt"}, 32'(core_gnt), 32'h0);
    chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 32'h0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_rvalid"}, 32'({core_rvalid, dbg_rvalid}), 32'h0);
    chk({tag, "_rdata"}, core_rdata | dbg_rdata, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    chk({tag, "_stats"}, stat_core_grants | stat_dbg_grants | stat_conflicts, 32'h0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int ew, aw;
    bit cp, dp, lk, c_we, d_we;
    logic [15:0] c_addr, d_addr;
    logic [31:0] c_wd, d_wd;
    logic [3:0] c_ws, d_ws;
    cp = 1'b0; dp = 1'b0;
    c_we = 1'b0; d_we = 1'b0; c_addr = 16'h0; d_addr = 16'h0;
    c_wd = 32'h0; d_wd = 32'h0; c_ws = 4'h0; d_ws = 4'h0;
    for (int a = 0; a < 32; a++) begin
      tb_mem[a] = $urandom;
      ref_mem[a] = tb_mem[a];
    end
    tb_mem[16'h0010] = 32'hDEAD_BEEF; ref_mem[16'h0010] = 32'hDEAD_BEEF;
    tb_mem[16'h0001] = 32'h1111_1111; ref_mem[16'h0001] = 32'h1111_1111;
    tb_mem[16'h0002] = 32'h2222_2222; ref_mem[16'h0002] = 32'h2222_2222;

    // Reset held with requests present: nothing may be granted.
    core_req = 1'b1; dbg_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("reset");
    core_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Core-only read, response next cycle.
    do_cycle(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, ew, aw);
    idle_cycle();
    chk("core_read_rvalid", 32'({core_rvalid, dbg_rvalid}), 32'h2);
    chk("core_read_rdata", core_rdata, 32'hDEAD_BEEF);

    // Debug-only write, ack next cycle.
    do_cycle(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b1, 16'h0100, 32'h1234_5678, 4'b0011,
             1'b0, ew, aw);
    idle_cycle();
    chk("dbg_write_ack", 32'({core_rvalid, dbg_rvalid}), 32'h1);

    // Starvation guard: both requesting, debug wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 1'b0, 16'(i), 32'h0, 4'h0, 1'b1, 1'b0, 16'(i + 8), 32'h0, 4'h0, 1'b0,
               ew, aw);
      chk("starve_pattern", 32'(aw), (i % 5 == 4) ? 32'd2 : 32'd1);
    end
    idle_cycle();

    // Debug lock burst, then core wins on the first unlocked cycle.
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 1'b0, 16'h3, 32'h0, 4'h0, 1'b1, 1'b1, 16'(16'h20 + i), 32'(i), 4'hF,
               1'b1, ew, aw);
      chk("lock_dbg_wins", 32'(aw), 32'd2);
    end
    do_cycle(1'b1, 1'b0, 16'h3, 32'h0, 4'h0, 1'b1, 1'b0, 16'h4, 32'h0, 4'h0, 1'b0, ew, aw);
    chk("unlock_core_wins", 32'(aw), 32'd1);
    idle_cycle();
    idle_cycle();

    // Interleaved ownership: core at n, debug at n+1.
    do_cycle(1'b1, 1'b0, 16'h0001, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, ew, aw);
    do_cycle(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 1'b0, 16'h0002, 32'h0, 4'h0, 1'b0, ew, aw);
    chk("inter_core_rsp", 32'({core_rvalid, dbg_rvalid}), 32'h2);
    chk("inter_core_data", core_rdata, 32'h1111_1111);
    idle_cycle();
    chk("inter_dbg_rsp", 32'({core_rvalid, dbg_rvalid}), 32'h1);
    chk("inter_dbg_data", dbg_rdata, 32'h2222_2222);

    // Randomized traffic honouring hold-until-grant.
    for (int n = 0; n < 2000; n++) begin
      if (!cp && $urandom_range(0, 9) < 6) begin
        cp = 1'b1; c_we = 1'($urandom_range(0, 1)); c_addr = 16'($urandom_range(0, 31));
        c_wd = $urandom; c_ws = 4'($urandom_range(1, 15));
      end
      if (!dp && $urandom_range(0, 9) < 6) begin
        dp = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = 16'($urandom_range(0, 31));
        d_wd = $urandom; d_ws = 4'($urandom_range(1, 15));
      end
      lk = ($urandom_range(0, 7) == 0);
      do_cycle(cp, c_we, c_addr, c_wd, c_ws, dp, d_we, d_addr, d_wd, d_ws, lk, ew, aw);
      if (ew == 1) cp = 1'b0;
      if (ew == 2) dp = 1'b0;
    end
    repeat (3) idle_cycle();

`ifdef DMEM_ARB_STATS_EN
    chk("stat_core_grants", stat_core_grants, ref_sc);
    chk("stat_dbg_grants", stat_dbg_grants, ref_sd);
    chk("stat_conflicts", stat_conflicts, ref_scf);
`endif

    // Reset asserted between grant and response: the response must vanish.
    do_cycle(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, ew, aw);
    @(posedge clk);
    #2 reset_n = 1'b0;
    sb.delete();
    ref_wait = 0;
`ifdef DMEM_ARB_STATS_EN
    ref_sc = 0; ref_sd = 0; ref_scf = 0;
`endif
    #1 chk_reset_outputs("midop_reset");
    core_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) idle_cycle();
    chk_reset_outputs("post_reset");
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path and the JTAG debug system-bus access path.
- The debug path lets the debugger read and write DMEM while the core runs, without force/release or $readmemh preloading.
- Sits between the core, the debug module and the data memory instance in the SoC.
- Grants are fixed-priority with a starvation guard, plus a debug lock for burst transfers. A response pipeline routes read data back to the owning requester.

Parameters:
- ADDR_W, 16: word-address width of DMEM (65536 words).
- READ_LATENCY, 1: cycles from mem_en to valid mem_rdata. Legal values 1..4.
- MAX_WAIT, 8: maximum consecutive lost cycles for debug before it is forced to win. Legal values 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- core_req  in  1  core access request
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  word address
- core_wdata  in  32  write data
- core_wsel  in  4  byte enables
- core_gnt  out  1  request accepted this cycle
- core_rvalid  out  1  response for the core
- core_rdata  out  32  read data for the core
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_wsel  in  1/1/ADDR_W/32/4  same meaning as the core fields, for the debug path
- dbg_lock  in  1  debug burst lock
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/32  same meaning as the core outputs, for the debug path
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_wsel  out  4  memory byte enables
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: every output is 0, wait_cnt is 0 and the response pipeline is empty.
- Reset is asynchronous. Assertion mid-transfer discards all in-flight responses. No rvalid is produced for accesses issued before reset.
- Requester rule: req and its attributes are held stable until gnt is seen. gnt is combinational from req in the same cycle, and the access is issued to memory in that cycle.
- One grant per cycle; core_gnt and dbg_gnt are never both 1.
- mem_* outputs are combinational copies of the winner's fields. When no request is granted: mem_en=0, mem_we=0, and addr/wdata/wsel are don't-care.
- Arbitration, evaluated in priority order:
  - dbg_req & dbg_lock: debug wins.
  - dbg_req & wait_cnt >= MAX_WAIT: debug wins.
  - core_req: core wins.
  - dbg_req: debug wins.
- wait_cnt (8 bits):
  - increments when dbg_req=1 and debug loses;
  - clears when debug is granted or dbg_req=0;
  - saturates at 255.
- Response pipeline: a shift register of depth READ_LATENCY with entries {valid, owner}. It is loaded each cycle with {mem_en, winner}.
- At the pipeline output, the owner's rvalid pulses for 1 cycle, and its rdata = mem_rdata for reads.
  - Writes also return rvalid as a completion ack; rdata is then don't-care.
  - The non-owner's rdata is held at 0.
- Back-to-back grants to alternating owners every cycle are legal. Responses return strictly in issue order.
- dbg_lock without dbg_req has no effect.
- dbg_lock held indefinitely starves the core. This is by design; debug software bounds its bursts.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, the block adds:
  - output stat_core_grants[31:0]: saturating count of core grants;
  - output stat_dbg_grants[31:0]: saturating count of debug grants;
  - output stat_conflicts[31:0]: cycles with core_req & dbg_req both 1;
  - input stat_clr: synchronous clear of all three counters; takes priority over increment in the same cycle.
- All counters reset to 0 on reset_n.
- When not defined, these ports and registers do not exist and arbitration behaviour is identical.

Test Plan (MAX_WAIT=4, READ_LATENCY=1):
- Core-only read: core_req=1, addr=0x0010, mem_rdata=0xDEADBEEF.
  - Expect core_gnt same cycle with mem_en=1, mem_addr=0x0010.
  - Expect core_rvalid=1 with core_rdata=0xDEADBEEF one cycle later; dbg_rvalid stays 0.
- Debug-only write: dbg_req=1, we=1, addr=0x0100, wdata=0x12345678, wsel=4'b0011.
  - Expect dbg_gnt same cycle, mem_we=1, mem_wsel=4'b0011.
  - Expect dbg_rvalid pulse next cycle.
- Starvation: core_req and dbg_req both held high continuously.
  - Expect core granted cycles 0-3, debug granted cycle 4, wait_cnt back to 0.
  - Expect the pattern to repeat with period 5.
- Lock: dbg_lock=1, both requesting for 6 cycles.
  - Expect dbg_gnt on all 6 cycles and core_gnt=0.
  - Expect core granted the first cycle after dbg_lock drops.
- Interleaved ownership: core read at 0x1 in cycle n, debug read at 0x2 in cycle n+1.
  - Expect core_rvalid at n+1 only, dbg_rvalid at n+2 only, each with its own data.
- Reset mid-op: assert reset_n=0 asynchronously between grant and response.
  - Expect no rvalid afterwards, all outputs 0, and stat counters (if DMEM_ARB_STATS_EN) at 0.
